nf_rf_wr_arb: RTL and testbench

Write-port arbiter and load scoreboard for the core register file, which has a single write port (address, data, enable) and forwards write data on read/write address match.
- Shares the write port between the in-order pipeline writeback and asynchronous load-data returns from the LSU. Load returns are buffered in a small FIFO.
- Tracks destination registers of outstanding loads and raises a read-hazard stall to decode.

---
 rtl/nf_rf_arb_pkg.sv | 16 +
 rtl/nf_rf_ret_fifo.sv | 71 +++++++
 rtl/nf_rf_wr_arb.sv | 153 +++++++++++++++
 tb/tb_nf_rf_wr_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nf_rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package nf_rf_arb_pkg;

  // Architectural register count (reg_number).
  localparam int unsigned RegNumber = 32;
  localparam int unsigned RegAddrW  = $clog2(RegNumber);

  localparam logic [RegAddrW-1:0] RF_X0 = 5'd0;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [RegAddrW-1:0] wa;
    logic [31:0]         wd;
  } rf_wr_t;

endpackage

// File: rtl/nf_rf_ret_fifo.sv
// Load-return buffer: synchronous FIFO of register-file writes.
module nf_rf_ret_fifo
  import nf_rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  rf_wr_t push_data,
  input  logic   pop,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  rf_wr_t            mem_q [DEPTH];
  rf_wr_t            mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous clear; stale entries are simply abandoned.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nf_rf_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered load
// returns fill idle slots. Also keeps the load scoreboard that drives the decode stall.
module nf_rf_wr_arb
  import nf_rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned STARVE_MAX = 4   // expected >= 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  output logic        wb_stall,
  input  logic        lsu_req,
  input  logic [4:0]  lsu_rd,
  output logic        lsu_req_ready,
  input  logic        lsu_rvalid,
  input  logic [4:0]  lsu_wa,
  input  logic [31:0] lsu_wd,
  output logic        lsu_rready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        hz_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  logic [RegNumber-1:0] pending_q, pending_d;
  logic [OutW-1:0]      outstanding_q, outstanding_d;
  logic [StW-1:0]       starve_q, starve_d;
  logic                 wb_stall_q, wb_stall_d;

  rf_wr_t fifo_head, fifo_in;
  logic   fifo_full, fifo_empty;
  logic   wb_act, pop, push, ret_acc, req_acc;
  logic   clr1, clr2;

  assign wb_act  = wb_we && (wb_wa != RF_X0);
  assign pop     = !fifo_empty && !wb_act;
  assign ret_acc = lsu_rvalid && !fifo_full;
  // Returns to x0 are counted but dropped.
  assign push    = ret_acc && (lsu_wa != RF_X0);
  assign req_acc = lsu_req && lsu_req_ready;

  assign fifo_in.wa = lsu_wa;
  assign fifo_in.wd = lsu_wd;

  nf_rf_ret_fifo #(
    .DEPTH (DEPTH)
  ) u_ret_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port mux; idle port drives zeros since the RF forwards on address match alone.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = RF_X0;
    rf_wd = '0;
    if (wb_act) begin
      rf_we = 1'b1;
      rf_wa = wb_wa;
      rf_wd = wb_wd;
    end else if (!fifo_empty) begin
      rf_we = 1'b1;
      rf_wa = fifo_head.wa;
      rf_wd = fifo_head.wd;
    end
  end

  // Handshakes: same-rd reissue is held off (WAW) as is issue beyond MAX_OUT.
  always_comb begin
    lsu_req_ready = !pending_q[lsu_rd] && (outstanding_q < OutW'(MAX_OUT));
    lsu_rready    = !fifo_full;
    wb_stall      = wb_stall_q;
  end

  // Decode hazard, masked when this cycle's FIFO write forwards the value.
  always_comb begin
    clr1     = pop && (fifo_head.wa == ra1);
    clr2     = pop && (fifo_head.wa == ra2);
    hz_stall = ((ra1 != RF_X0) && pending_q[ra1] && !clr1) ||
               ((ra2 != RF_X0) && pending_q[ra2] && !clr2);
  end

  // Scoreboard and outstanding-load count.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    if (req_acc && (lsu_rd != RF_X0)) begin
      pending_d[lsu_rd] = 1'b1;
    end
    if (pop) begin
      pending_d[fifo_head.wa] = 1'b0;
    end
    unique case ({req_acc, ret_acc})
      2'b10:   outstanding_d = outstanding_q + OutW'(1);
      2'b01:   outstanding_d = outstanding_q - OutW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Starvation counter; requests a one-cycle writeback bubble when it reaches STARVE_MAX-1.
  always_comb begin
    starve_d   = starve_q;
    wb_stall_d = 1'b0;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else begin
      if (starve_q < StW'(STARVE_MAX)) begin
        starve_d = starve_q + StW'(1);
      end
      // Saturation keeps starve_d from revisiting this value, so the request fires once.
      if (starve_d == StW'(STARVE_MAX - 1) && starve_q != starve_d) begin
        wb_stall_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      starve_q      <= '0;
      wb_stall_q    <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      starve_q      <= starve_d;
      wb_stall_q    <= wb_stall_d;
    end
  end

`ifndef SYNTHESIS
  // A non-x0 return must target a register with a load in flight.
  a_ret_pending : assert property (@(posedge clk) disable iff (!resetn)
    (ret_acc && (lsu_wa != RF_X0)) |-> pending_q[lsu_wa]);
`endif

endmodule

// File: tb/tb_nf_rf_wr_arb.sv
// Scoreboard bench for nf_rf_wr_arb: expected RF writes are queued by the stimulus
// and consumed by a monitor whenever rf_we is seen.
module tb_nf_rf_wr_arb;
  import nf_rf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        wb_stall;
  logic        lsu_req;
  logic [4:0]  lsu_rd;
  logic        lsu_req_ready;
  logic        lsu_rvalid;
  logic [4:0]  lsu_wa;
  logic [31:0] lsu_wd;
  logic        lsu_rready;
  logic [4:0]  ra1, ra2;
  logic        hz_stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;
  rf_wr_t exp_q[$];

  always #5 clk = ~clk;

  nf_rf_wr_arb dut (
    .clk           (clk),
    .resetn        (resetn),
    .wb_we         (wb_we),
    .wb_wa         (wb_wa),
    .wb_wd         (wb_wd),
    .wb_stall      (wb_stall),
    .lsu_req       (lsu_req),
    .lsu_rd        (lsu_rd),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rvalid    (lsu_rvalid),
    .lsu_wa        (lsu_wa),
    .lsu_wd        (lsu_wd),
    .lsu_rready    (lsu_rready),
    .ra1           (ra1),
    .ra2           (ra2),
    .hz_stall      (hz_stall),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, then clear all stimulus.
  task automatic cyc();
    @(posedge clk);
    #1;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    lsu_req = 0; lsu_rd = 0;
    lsu_rvalid = 0; lsu_wa = 0; lsu_wd = 0;
    ra1 = 0; ra2 = 0;
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
    rf_wr_t e;
    e.wa = wa;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    wb_we = 1; wb_wa = wa; wb_wd = wd;
    expect_wr(wa, wd);
  endtask

  // Monitor: every RF write outside reset must match the head of the expected queue.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got wa=%0d wd=%h expected no write", rf_wa, rf_wd);
      end else begin
        rf_wr_t e;
        e = exp_q.pop_front();
        if (rf_wa !== e.wa || rf_wd !== e.wd) begin
          errors++;
          $display("FAIL rf_write: got wa=%0d wd=%h expected wa=%0d wd=%h",
                   rf_wa, rf_wd, e.wa, e.wd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    lsu_req = 0; lsu_rd = 0;
    lsu_rvalid = 0; lsu_wa = 0; lsu_wd = 0;
    ra1 = 0; ra2 = 0;

    // Reset, then idle outputs.
    cyc(); cyc();
    resetn = 1;
    @(negedge clk);
    chk("reset_rf_we", {31'd0, rf_we}, 0);
    chk("reset_rf_wa", {27'd0, rf_wa}, 0);
    chk("reset_rf_wd", rf_wd, 0);
    chk("reset_hz", {31'd0, hz_stall}, 0);
    chk("reset_rready", {31'd0, lsu_rready}, 1);
    chk("reset_req_ready", {31'd0, lsu_req_ready}, 1);
    chk("reset_wb_stall", {31'd0, wb_stall}, 0);

    // Load rd=5, return DEADBEEF, hazard before and during the write.
    cyc(); lsu_req = 1; lsu_rd = 5; ra1 = 5;
    @(negedge clk);
    chk("ld5_req_ready", {31'd0, lsu_req_ready}, 1);
    chk("ld5_hz_issue", {31'd0, hz_stall}, 0);
    cyc(); lsu_rvalid = 1; lsu_wa = 5; lsu_wd = 32'hDEADBEEF; ra1 = 5;
    @(negedge clk);
    chk("ld5_hz_pending", {31'd0, hz_stall}, 1);
    chk("ld5_rready", {31'd0, lsu_rready}, 1);
    chk("ld5_no_write_yet", {31'd0, rf_we}, 0);
    cyc(); ra1 = 5; expect_wr(5, 32'hDEADBEEF);
    @(negedge clk);
    chk("ld5_write_we", {31'd0, rf_we}, 1);
    chk("ld5_hz_fwd", {31'd0, hz_stall}, 0);
    cyc(); ra1 = 5;
    @(negedge clk);
    chk("ld5_hz_clear", {31'd0, hz_stall}, 0);
    chk("idle_rf_wa", {27'd0, rf_wa}, 0);

    // Starvation: return buffered behind four writebacks to x7.
    cyc(); lsu_req = 1; lsu_rd = 9;
    cyc(); lsu_rvalid = 1; lsu_wa = 9; lsu_wd = 32'h1111; wb(7, 32'hA0);
    for (int i = 1; i <= 4; i++) begin
      cyc(); wb(7, 32'hA0 + i); ra2 = 9;
      @(negedge clk);
      chk($sformatf("starve_wb_stall_c%0d", i), {31'd0, wb_stall}, (i == 4) ? 1 : 0);
      chk($sformatf("starve_hz_c%0d", i), {31'd0, hz_stall}, 1);
    end
    cyc(); expect_wr(9, 32'h1111);
    @(negedge clk);
    chk("starve_stall_drop", {31'd0, wb_stall}, 0);

    // Outstanding limit and WAW hold-off.
    cyc(); lsu_req = 1; lsu_rd = 3;
    @(negedge clk); chk("out_rd3_ready", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_req = 1; lsu_rd = 4;
    @(negedge clk); chk("out_rd4_ready", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_req = 1; lsu_rd = 6;
    @(negedge clk); chk("out_third_blocked", {31'd0, lsu_req_ready}, 0);
    cyc(); lsu_req = 1; lsu_rd = 3;
    @(negedge clk); chk("out_waw_rd3_full", {31'd0, lsu_req_ready}, 0);
    cyc(); lsu_rvalid = 1; lsu_wa = 3; lsu_wd = 32'h33;
    cyc(); lsu_req = 1; lsu_rd = 4; expect_wr(3, 32'h33);
    @(negedge clk); chk("waw_rd4_blocked", {31'd0, lsu_req_ready}, 0);
    cyc(); lsu_req = 1; lsu_rd = 3;
    @(negedge clk); chk("rd3_reissue_ready", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_rvalid = 1; lsu_wa = 4; lsu_wd = 32'h44;
    cyc(); lsu_rvalid = 1; lsu_wa = 3; lsu_wd = 32'h333; expect_wr(4, 32'h44);
    cyc(); expect_wr(3, 32'h333);

    // Load to x0 is counted then discarded.
    cyc(); lsu_req = 1; lsu_rd = 0;
    @(negedge clk); chk("x0_req_ready", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_rvalid = 1; lsu_wa = 0; lsu_wd = 32'hBAD0;
    @(negedge clk);
    chk("x0_no_write", {31'd0, rf_we}, 0);
    chk("x0_hz", {31'd0, hz_stall}, 0);
    cyc();
    @(negedge clk); chk("x0_no_write_after", {31'd0, rf_we}, 0);
    cyc(); lsu_req = 1; lsu_rd = 10;
    @(negedge clk); chk("x0_out_rd10", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_req = 1; lsu_rd = 11;
    @(negedge clk); chk("x0_out_rd11", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_req = 1; lsu_rd = 12;
    @(negedge clk); chk("x0_out_rd12_blocked", {31'd0, lsu_req_ready}, 0);
    cyc(); lsu_rvalid = 1; lsu_wa = 10; lsu_wd = 32'h000A;
    cyc(); lsu_rvalid = 1; lsu_wa = 11; lsu_wd = 32'h000B; expect_wr(10, 32'h000A);
    cyc(); expect_wr(11, 32'h000B);

    // FIFO full behind writebacks; held return accepted after the first pop.
    cyc(); lsu_req = 1; lsu_rd = 13;
    cyc(); lsu_req = 1; lsu_rd = 14;
    cyc(); lsu_rvalid = 1; lsu_wa = 13; lsu_wd = 32'hD13; wb(7, 32'hB3);
    cyc(); lsu_req = 1; lsu_rd = 15; lsu_rvalid = 1; lsu_wa = 14; lsu_wd = 32'hD14;
    wb(7, 32'hB4);
    @(negedge clk); chk("full_rd15_ready", {31'd0, lsu_req_ready}, 1);
    cyc(); lsu_rvalid = 1; lsu_wa = 15; lsu_wd = 32'hD15; wb(7, 32'hB5);
    @(negedge clk); chk("full_rready_wb", {31'd0, lsu_rready}, 0);
    cyc(); lsu_rvalid = 1; lsu_wa = 15; lsu_wd = 32'hD15; expect_wr(13, 32'hD13);
    @(negedge clk); chk("full_rready_pop1", {31'd0, lsu_rready}, 0);
    cyc(); lsu_rvalid = 1; lsu_wa = 15; lsu_wd = 32'hD15; expect_wr(14, 32'hD14);
    @(negedge clk); chk("full_rready_after", {31'd0, lsu_rready}, 1);
    cyc(); expect_wr(15, 32'hD15);

    // Reset with two buffered returns discards them.
    cyc(); lsu_req = 1; lsu_rd = 20;
    cyc(); lsu_req = 1; lsu_rd = 21;
    cyc(); lsu_rvalid = 1; lsu_wa = 20; lsu_wd = 32'hE20; wb(7, 32'hC3);
    cyc(); lsu_rvalid = 1; lsu_wa = 21; lsu_wd = 32'hE21; wb(7, 32'hC4);
    cyc(); resetn = 0;
    cyc(); resetn = 1; ra1 = 20; ra2 = 21;
    @(negedge clk);
    chk("rst_mid_no_write", {31'd0, rf_we}, 0);
    chk("rst_mid_hz", {31'd0, hz_stall}, 0);
    chk("rst_mid_rready", {31'd0, lsu_rready}, 1);
    cyc(); lsu_rd = 20;
    @(negedge clk);
    chk("rst_mid_no_write2", {31'd0, rf_we}, 0);
    chk("rst_mid_pending20", {31'd0, lsu_req_ready}, 1);
    chk("rst_mid_rf_wd", rf_wd, 0);

    cyc();
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
